perf_monitor: RTL and testbench

- Cycle/instruction performance monitor that sits directly downstream of the RISC-V core's retire stage.
- Counts elapsed clock cycles and retired instructions between program start and program halt.
- Asserts a level done when the program finishes and exposes clock_count/instr_count so the bench or host can compute CPI.
- Includes a watchdog that ends a run that never halts.

---
 rtl/perf_monitor.sv | 117 +++++++++++
 tb/tb_perf_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Cycle/instruction performance monitor with watchdog, placed after the core's retire stage.
// Optional stall counter enabled by defining PERF_STALL_COUNT_EN.
module perf_monitor #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_CYCLES = 1000000000
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic             instr_retire,
  input  logic             halt,
  input  logic             stall,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [WIDTH-1:0] clock_count,
  output logic [WIDTH-1:0] instr_count,
  output logic [WIDTH-1:0] stall_count
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_CYCLES);
  localparam logic [WIDTH-1:0] One      = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StTimeout} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] clock_q, clock_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] retire_inc;

  assign retire_inc = {{(WIDTH-1){1'b0}}, instr_retire};

  always_comb begin
    state_d = state_q;
    clock_d = clock_q;
    instr_d = instr_q;
    if (clear) begin
      state_d = StIdle;
      clock_d = '0;
      instr_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            // The start cycle is counted as cycle 1.
            clock_d = One;
            instr_d = retire_inc;
            state_d = (MaxCount == One) ? StTimeout : StRun;
          end
        end
        StRun: begin
          clock_d = clock_q + One;
          instr_d = instr_q + retire_inc;
          // Halt takes priority over the watchdog in the same cycle.
          if (halt) begin
            state_d = StDone;
          end else if (clock_d == MaxCount) begin
            state_d = StTimeout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= StIdle;
      clock_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      clock_q <= clock_d;
      instr_q <= instr_d;
    end
  end

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign timeout     = (state_q == StTimeout);
  assign clock_count = clock_q;
  assign instr_count = instr_q;

`ifdef PERF_STALL_COUNT_EN
  logic [WIDTH-1:0] stall_q, stall_d;
  logic [WIDTH-1:0] stall_inc;

  assign stall_inc = {{(WIDTH-1){1'b0}}, stall};

  always_comb begin
    stall_d = stall_q;
    if (clear) begin
      stall_d = '0;
    end else if (state_q == StIdle && start) begin
      stall_d = stall_inc;
    end else if (state_q == StRun) begin
      stall_d = stall_q + stall_inc;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_count  = '0;
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench: three perf_monitor instances with different watchdog limits share one
// stimulus stream and are compared every cycle against a behavioural reference model.
module tb_perf_monitor;

  localparam int N = 3;
  localparam int PIdle = 0, PRun = 1, PDone = 2, PTo = 3;
`ifdef PERF_STALL_COUNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, instr_retire = 1'b0, halt = 1'b0, stall = 1'b0, clear = 1'b0;

  logic        busy_w [N];
  logic        done_w [N];
  logic        to_w   [N];
  logic [31:0] clk_w  [N];
  logic [31:0] ins_w  [N];
  logic [31:0] stl_w  [N];

  int          m_ph  [N];
  longint      m_cyc [N];
  longint      m_ins [N];
  longint      m_stl [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int max_of(input int i);
    return (i == 0) ? 1000 : (i == 1) ? 16 : 8;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    perf_monitor #(
      .WIDTH     (32),
      .MAX_CYCLES((g == 0) ? 1000 : (g == 1) ? 16 : 8)
    ) u_dut (
      .CLOCK_50    (clk),
      .rst         (rst),
      .start       (start),
      .instr_retire(instr_retire),
      .halt        (halt),
      .stall       (stall),
      .clear       (clear),
      .busy        (busy_w[g]),
      .done        (done_w[g]),
      .timeout     (to_w[g]),
      .clock_count (clk_w[g]),
      .instr_count (ins_w[g]),
      .stall_count (stl_w[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Spec-level reference: one run between start and halt/watchdog, counts frozen afterwards.
  task automatic model_step(input int i, input logic r, input logic s, input logic ret,
                            input logic h, input logic st, input logic cl);
    if (r || cl) begin
      m_ph[i] = PIdle; m_cyc[i] = 0; m_ins[i] = 0; m_stl[i] = 0;
    end else if (m_ph[i] == PIdle) begin
      if (s) begin
        m_cyc[i] = 1;
        m_ins[i] = ret ? 1 : 0;
        m_stl[i] = (StallEn && st) ? 1 : 0;
        m_ph[i]  = (max_of(i) == 1) ? PTo : PRun;
      end
    end else if (m_ph[i] == PRun) begin
      m_cyc[i] += 1;
      if (ret) m_ins[i] += 1;
      if (StallEn && st) m_stl[i] += 1;
      if (h) m_ph[i] = PDone;
      else if (m_cyc[i] == max_of(i)) m_ph[i] = PTo;
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic ret, input logic h,
                      input logic st, input logic cl);
    rst = r; start = s; instr_retire = ret; halt = h; stall = st; clear = cl;
    for (int i = 0; i < N; i++) model_step(i, r, s, ret, h, st, cl);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d.busy", i), 64'(busy_w[i]), 64'(m_ph[i] == PRun));
      check($sformatf("u%0d.done", i), 64'(done_w[i]), 64'(m_ph[i] == PDone));
      check($sformatf("u%0d.timeout", i), 64'(to_w[i]), 64'(m_ph[i] == PTo));
      check($sformatf("u%0d.clock_count", i), 64'(clk_w[i]), 64'(m_cyc[i]));
      check($sformatf("u%0d.instr_count", i), 64'(ins_w[i]), 64'(m_ins[i]));
      check($sformatf("u%0d.stall_count", i), 64'(stl_w[i]), 64'(m_stl[i]));
      if (done_w[i]) begin
        check($sformatf("u%0d.inv_ins_le_clk", i), 64'(ins_w[i] <= clk_w[i]), 64'd1);
        check($sformatf("u%0d.inv_clk_ge1", i), 64'(clk_w[i] >= 1), 64'd1);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    // Reset with random inputs.
    for (int k = 0; k < 3; k++)
      tick(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check("rst.busy", 64'(busy_w[0]), 64'd0);
    check("rst.clock_count", 64'(clk_w[0]), 64'd0);

    // Retire every cycle, halt on counted cycle 10.
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t1.done", 64'(done_w[0]), 64'd1);
    check("t1.clock_count", 64'(clk_w[0]), 64'd10);
    check("t1.instr_count", 64'(ins_w[0]), 64'd10);
    check("t1.max8_timeout", 64'(to_w[2]), 64'd1);
    check("t1.max8_clock_count", 64'(clk_w[2]), 64'd8);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Alternate retires, halt with retire on cycle 7, then 20 frozen cycles.
    for (int k = 1; k <= 7; k++) tick(1'b0, k == 1, k % 2 == 1, k == 7, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) tick(1'b0, 1'($urandom), k % 2 == 0, 1'($urandom), 1'b0, 1'b0);
    check("t2.done", 64'(done_w[0]), 64'd1);
    check("t2.clock_count", 64'(clk_w[0]), 64'd7);
    check("t2.instr_count", 64'(ins_w[0]), 64'd4);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Never halt: MAX_CYCLES=16 instance times out.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 22; k++) tick(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    check("t3.timeout", 64'(to_w[1]), 64'd1);
    check("t3.done", 64'(done_w[1]), 64'd0);
    check("t3.clock_count", 64'(clk_w[1]), 64'd16);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3.clear_count", 64'(clk_w[1]), 64'd0);
    for (int k = 1; k <= 5; k++) tick(1'b0, k == 1, 1'b1, k == 5, 1'b0, 1'b0);
    check("t3.rerun_clock_count", 64'(clk_w[1]), 64'd5);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Halt coincides with the watchdog limit of the MAX_CYCLES=8 instance.
    for (int k = 1; k <= 8; k++) tick(1'b0, k == 1, 1'b0, k == 8, 1'b0, 1'b0);
    check("t4.done", 64'(done_w[2]), 64'd1);
    check("t4.timeout", 64'(to_w[2]), 64'd0);
    check("t4.clock_count", 64'(clk_w[2]), 64'd8);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Clear mid-run, then start and clear together.
    for (int k = 1; k <= 3; k++) tick(1'b0, k == 1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5.busy", 64'(busy_w[0]), 64'd0);
    check("t5.done", 64'(done_w[0]), 64'd0);
    check("t5.clock_count", 64'(clk_w[0]), 64'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5.start_clear_busy", 64'(busy_w[0]), 64'd0);
    check("t5.start_clear_count", 64'(clk_w[0]), 64'd0);
    idle(2);

    // Stalls on cycles 2, 3 and 6 of a 6-cycle run.
    for (int k = 1; k <= 6; k++)
      tick(1'b0, k == 1, 1'b0, k == 6, k == 2 || k == 3 || k == 6, 1'b0);
    check("t6.clock_count", 64'(clk_w[0]), 64'd6);
    check("t6.stall_count", 64'(stl_w[0]), StallEn ? 64'd3 : 64'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      tick($urandom_range(99) < 1, $urandom_range(99) < 10, $urandom_range(99) < 50,
           $urandom_range(99) < 5, $urandom_range(99) < 30, $urandom_range(99) < 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
